// File: rtl/ram_port_arbiter_if.sv
// Bundles the requester, testbench-override and RAM-side buses of the RAM port arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface ram_port_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic                 tbCTRL;
  logic                 tbREN;
  logic                 tbWEN;
  logic [AW-1:0]        tbaddr;
  logic [DW-1:0]        tbstore;

  logic [NPORTS-1:0]    req_ren;
  logic [NPORTS-1:0]    req_wen;
  logic [NPORTS*AW-1:0] req_addr;
  logic [NPORTS*DW-1:0] req_store;
  logic [NPORTS-1:0]    req_wait;
  logic [NPORTS-1:0]    req_err;
  logic [DW-1:0]        req_load;
  logic [NPORTS-1:0]    grant;

  logic                 ramREN;
  logic                 ramWEN;
  logic [AW-1:0]        ramaddr;
  logic [DW-1:0]        ramstore;
  logic [DW-1:0]        ramload;
  logic [1:0]           ramstate;

  modport slave (
    input  tbCTRL, tbREN, tbWEN, tbaddr, tbstore,
    input  req_ren, req_wen, req_addr, req_store,
    output req_wait, req_err, req_load, grant,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport master (
    output tbCTRL, tbREN, tbWEN, tbaddr, tbstore,
    output req_ren, req_wen, req_addr, req_store,
    input  req_wait, req_err, req_load, grant,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NPORTS requesters; the grant is
// registered and held until the RAM completes, with a testbench override on top.
//
// state | meaning
// IDLE  | no owner; RAM outputs quiet; picks next requester after last_q
// OWNED | port gidx_q drives the RAM until ACCESS/ERROR or it drops its request
module ram_port_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                CLK,
  input  logic                RST,
  ram_port_arbiter_if.slave   bus
);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gidx_q, gidx_d;

  logic [NPORTS-1:0] req;
  logic [IW-1:0]     sel;
  logic [NPORTS-1:0] sel_onehot;
  logic              found;
  int                idx;

  logic              ren_g, wen_g, req_g;
  logic [AW-1:0]     addr_g;
  logic [DW-1:0]     store_g;

  assign req       = bus.req_ren | bus.req_wen;
  assign req_g     = ren_g | wen_g;
  assign bus.grant = grant_q;

  // First requester scanning last_q+1, last_q+2, ... with wrap.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = (int'(last_q) + k) % NPORTS;
      for (int i = 0; i < NPORTS; i++) begin
        if (!found && (i == idx) && req[i]) begin
          sel   = IW'(i);
          found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      sel_onehot[i] = (sel == IW'(i));
    end
  end

  always_comb begin
    ren_g   = 1'b0;
    wen_g   = 1'b0;
    addr_g  = '0;
    store_g = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gidx_q == IW'(i)) begin
        ren_g   = bus.req_ren[i];
        wen_g   = bus.req_wen[i];
        addr_g  = bus.req_addr[i*AW +: AW];
        store_g = bus.req_store[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    gidx_d       = gidx_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.req_wait = req;
    bus.req_err  = '0;
    bus.req_load = bus.ramload;

    if (bus.tbCTRL) begin
      // Override aborts any owner but leaves the round-robin pointer alone.
      bus.ramREN   = bus.tbREN;
      bus.ramWEN   = bus.tbWEN;
      bus.ramaddr  = bus.tbaddr;
      bus.ramstore = bus.tbstore;
      state_d      = IDLE;
      grant_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d = OWNED;
            gidx_d  = sel;
            grant_d = sel_onehot;
          end
        end
        OWNED: begin
          bus.ramaddr  = addr_g;
          bus.ramstore = store_g;
          if (!req_g) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx_q;
          end else begin
            bus.ramWEN = wen_g;
            bus.ramREN = ren_g & ~wen_g;
            if ((bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR)) begin
              for (int i = 0; i < NPORTS; i++) begin
                if (gidx_q == IW'(i)) begin
                  bus.req_wait[i] = 1'b0;
                  bus.req_err[i]  = (bus.ramstate == RAM_ERROR);
                end
              end
              state_d = IDLE;
              grant_d = '0;
              last_d  = gidx_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NPORTS - 1);
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios on 2- and 4-port
// instances plus a randomized run against a cycle-level reference model.
module tb_ram_port_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  ram_port_arbiter_if #(.NPORTS(2), .AW(32), .DW(32)) b2 ();
  ram_port_arbiter_if #(.NPORTS(4), .AW(32), .DW(32)) b4 ();

  ram_port_arbiter #(.NPORTS(2), .AW(32), .DW(32)) dut2 (.CLK(CLK), .RST(RST), .bus(b2));
  ram_port_arbiter #(.NPORTS(4), .AW(32), .DW(32)) dut4 (.CLK(CLK), .RST(RST), .bus(b4));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    b2.tbCTRL = 0; b2.tbREN = 0; b2.tbWEN = 0; b2.tbaddr = '0; b2.tbstore = '0;
    b2.req_ren = '0; b2.req_wen = '0; b2.req_addr = '0; b2.req_store = '0;
    b2.ramload = '0; b2.ramstate = 2'd0;
    b4.tbCTRL = 0; b4.tbREN = 0; b4.tbWEN = 0; b4.tbaddr = '0; b4.tbstore = '0;
    b4.req_ren = '0; b4.req_wen = '0; b4.req_addr = '0; b4.req_store = '0;
    b4.ramload = '0; b4.ramstate = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.ramWEN, b2.ramaddr, b2.ramstore, b2.req_wait, b2.req_err, b2.req_load} !== '0) begin
      n_fail++; $display("FAIL reset2_outputs: got grant=%b ren=%b wen=%b addr=%h wait=%b err=%b expected all zero", b2.grant, b2.ramREN, b2.ramWEN, b2.ramaddr, b2.req_wait, b2.req_err);
    end
    n_tests++;
    if ({b4.grant, b4.ramREN, b4.ramWEN, b4.ramaddr, b4.ramstore, b4.req_wait, b4.req_err, b4.req_load} !== '0) begin
      n_fail++; $display("FAIL reset4_outputs: got grant=%b ren=%b wen=%b addr=%h wait=%b err=%b expected all zero", b4.grant, b4.ramREN, b4.ramWEN, b4.ramaddr, b4.req_wait, b4.req_err);
    end
    tick();
    RST = 1'b0;
    tick();
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.ramWEN, b2.req_wait} !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: got grant=%b ren=%b wen=%b wait=%b expected zero", b2.grant, b2.ramREN, b2.ramWEN, b2.req_wait);
    end
    tick();
  endtask

  task automatic test_read();
    do_reset();
    b2.req_ren = 2'b01; b2.req_addr[31:0] = 32'h40; b2.ramstate = 2'd0;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.req_wait} !== {2'b00, 1'b0, 2'b01}) begin
      n_fail++; $display("FAIL read_request_cycle: got grant=%b ren=%b wait=%b expected grant=00 ren=0 wait=01", b2.grant, b2.ramREN, b2.req_wait);
    end
    tick();
    b2.ramstate = 2'd1;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.ramWEN, b2.ramaddr, b2.req_wait} !== {2'b01, 1'b1, 1'b0, 32'h40, 2'b01}) begin
      n_fail++; $display("FAIL read_granted: got grant=%b ren=%b wen=%b addr=%h wait=%b expected 01 1 0 00000040 01", b2.grant, b2.ramREN, b2.ramWEN, b2.ramaddr, b2.req_wait);
    end
    tick();
    @(negedge CLK);
    n_tests++;
    if (b2.req_wait !== 2'b01) begin
      n_fail++; $display("FAIL read_busy_wait: got %b expected 01", b2.req_wait);
    end
    tick();
    b2.ramstate = 2'd2; b2.ramload = 32'hDEADBEEF;
    @(negedge CLK);
    n_tests++;
    if ({b2.req_wait, b2.req_err, b2.req_load} !== {2'b00, 2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL read_access: got wait=%b err=%b load=%h expected 00 00 deadbeef", b2.req_wait, b2.req_err, b2.req_load);
    end
    tick();
    b2.req_ren = 2'b00; b2.ramstate = 2'd0; b2.ramload = '0;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN} !== 3'b000) begin
      n_fail++; $display("FAIL read_release: got grant=%b ren=%b expected 00 0", b2.grant, b2.ramREN);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rr [8];
    exp_rr = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    b2.req_ren = 2'b11; b2.ramstate = 2'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_tests++;
      if (b2.grant !== exp_rr[i]) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, b2.grant, exp_rr[i]);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w [6];
    exp_w = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    do_reset();
    b4.req_ren = 4'b1010; b4.ramstate = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      n_tests++;
      if (b4.grant !== exp_w[i]) begin
        n_fail++; $display("FAIL wrap_grant[%0d]: got %b expected %b", i, b4.grant, exp_w[i]);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    do_reset();
    b2.req_ren = 2'b10; b2.req_wen = 2'b10;
    b2.req_addr[63:32] = 32'h80; b2.req_store[63:32] = 32'h1234; b2.ramstate = 2'd1;
    tick();
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramWEN, b2.ramREN, b2.ramaddr, b2.ramstore} !== {2'b10, 1'b1, 1'b0, 32'h80, 32'h1234}) begin
      n_fail++; $display("FAIL write_drive: got grant=%b wen=%b ren=%b addr=%h store=%h expected 10 1 0 00000080 00001234", b2.grant, b2.ramWEN, b2.ramREN, b2.ramaddr, b2.ramstore);
    end
    tick();
    b2.ramstate = 2'd2;
    @(negedge CLK);
    n_tests++;
    if (b2.req_wait !== 2'b00) begin
      n_fail++; $display("FAIL write_done_wait: got %b expected 00", b2.req_wait);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_error();
    do_reset();
    b2.req_ren = 2'b01; b2.req_addr[31:0] = 32'h44; b2.ramstate = 2'd1;
    tick();
    b2.ramstate = 2'd3;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.req_err, b2.req_wait} !== {2'b01, 2'b01, 2'b00}) begin
      n_fail++; $display("FAIL error_pulse: got grant=%b err=%b wait=%b expected 01 01 00", b2.grant, b2.req_err, b2.req_wait);
    end
    tick();
    b2.ramstate = 2'd0;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.req_err, b2.req_wait} !== {2'b00, 2'b00, 2'b01}) begin
      n_fail++; $display("FAIL error_after: got grant=%b err=%b wait=%b expected 00 00 01", b2.grant, b2.req_err, b2.req_wait);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_tbctrl();
    do_reset();
    b2.req_ren = 2'b01; b2.req_addr[31:0] = 32'h40; b2.ramstate = 2'd1;
    tick();
    b2.tbCTRL = 1; b2.tbWEN = 1; b2.tbaddr = 32'h99; b2.tbstore = 32'h5555;
    b2.ramload = 32'hCAFE; b2.ramstate = 2'd3;
    @(negedge CLK);
    n_tests++;
    if ({b2.ramWEN, b2.ramREN, b2.ramaddr, b2.ramstore, b2.req_wait, b2.req_err, b2.req_load, b2.grant}
        !== {1'b1, 1'b0, 32'h99, 32'h5555, 2'b01, 2'b00, 32'hCAFE, 2'b01}) begin
      n_fail++; $display("FAIL tb_override: got wen=%b ren=%b addr=%h store=%h wait=%b err=%b load=%h grant=%b expected 1 0 99 5555 01 00 cafe 01", b2.ramWEN, b2.ramREN, b2.ramaddr, b2.ramstore, b2.req_wait, b2.req_err, b2.req_load, b2.grant);
    end
    tick();
    @(negedge CLK);
    n_tests++;
    if (b2.grant !== 2'b00) begin
      n_fail++; $display("FAIL tb_abort_grant: got %b expected 00", b2.grant);
    end
    tick();
    b2.tbCTRL = 0; b2.tbWEN = 0; b2.tbaddr = '0; b2.tbstore = '0; b2.ramload = '0; b2.ramstate = 2'd1;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.ramWEN} !== 4'b0000) begin
      n_fail++; $display("FAIL tb_fall_idle: got grant=%b ren=%b wen=%b expected 00 0 0", b2.grant, b2.ramREN, b2.ramWEN);
    end
    tick();
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.ramaddr} !== {2'b01, 1'b1, 32'h40}) begin
      n_fail++; $display("FAIL tb_regrant: got grant=%b ren=%b addr=%h expected 01 1 00000040", b2.grant, b2.ramREN, b2.ramaddr);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    b2.req_ren = 2'b10; b2.req_addr[63:32] = 32'h80; b2.ramstate = 2'd1;
    tick();
    @(negedge CLK);
    n_tests++;
    if (b2.grant !== 2'b10) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b expected 10", b2.grant);
    end
    tick();
    RST = 1'b1; b2.req_ren = 2'b11;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({b2.grant, b2.ramREN, b2.ramWEN, b2.ramaddr} !== '0) begin
      n_fail++; $display("FAIL rst_mid_idle: got grant=%b ren=%b wen=%b addr=%h expected zero", b2.grant, b2.ramREN, b2.ramWEN, b2.ramaddr);
    end
    tick();
    @(negedge CLK);
    n_tests++;
    if (b2.grant !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_winner: got %b expected 01", b2.grant);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  // Reference model: owner is the port holding the RAM (-1 when none),
  // last is the most recently served port.
  task automatic test_random();
    int owner = -1;
    int last  = 1;
    int nxt_owner;
    int g;
    logic [1:0]  r;
    logic [1:0]  e_grant, e_wait, e_err;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      b2.req_ren   = 2'($urandom_range(0, 3));
      b2.req_wen   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      b2.req_addr  = {$urandom, $urandom};
      b2.req_store = {$urandom, $urandom};
      b2.ramstate  = 2'($urandom_range(0, 3));
      b2.ramload   = $urandom;
      b2.tbCTRL    = ($urandom_range(0, 9) == 0);
      b2.tbREN     = 1'($urandom_range(0, 1));
      b2.tbWEN     = 1'($urandom_range(0, 1));
      b2.tbaddr    = $urandom;
      b2.tbstore   = $urandom;
      @(negedge CLK);
      r         = b2.req_ren | b2.req_wen;
      e_grant   = (owner < 0) ? 2'b00 : (2'b01 << owner);
      e_wait    = r;
      e_err     = 2'b00;
      e_ren     = 1'b0;
      e_wen     = 1'b0;
      e_addr    = '0;
      e_store   = '0;
      nxt_owner = owner;
      if (b2.tbCTRL) begin
        e_ren = b2.tbREN; e_wen = b2.tbWEN; e_addr = b2.tbaddr; e_store = b2.tbstore;
        nxt_owner = -1;
      end else if (owner < 0) begin
        for (int k = 1; k <= 2; k++) begin
          if (nxt_owner < 0 && ((r >> ((last + k) % 2)) & 2'b01) != 0) nxt_owner = (last + k) % 2;
        end
      end else begin
        g       = owner;
        e_addr  = 32'(b2.req_addr >> (32 * g));
        e_store = 32'(b2.req_store >> (32 * g));
        if (((r >> g) & 2'b01) == 0) begin
          nxt_owner = -1; last = g;
        end else begin
          e_wen = 1'(b2.req_wen >> g);
          e_ren = 1'(b2.req_ren >> g) & !e_wen;
          if (b2.ramstate >= 2) begin
            e_wait = e_wait & ~(2'b01 << g);
            if (b2.ramstate == 3) e_err = 2'b01 << g;
            nxt_owner = -1; last = g;
          end
        end
      end
      n_tests++;
      if (b2.grant !== e_grant) begin
        n_fail++; $display("FAIL rand_grant c=%0d: got %b expected %b", c, b2.grant, e_grant);
      end
      n_tests++;
      if ({b2.ramREN, b2.ramWEN, b2.ramaddr, b2.ramstore} !== {e_ren, e_wen, e_addr, e_store}) begin
        n_fail++; $display("FAIL rand_ram c=%0d: got ren=%b wen=%b addr=%h store=%h expected %b %b %h %h", c, b2.ramREN, b2.ramWEN, b2.ramaddr, b2.ramstore, e_ren, e_wen, e_addr, e_store);
      end
      n_tests++;
      if (b2.req_wait !== e_wait) begin
        n_fail++; $display("FAIL rand_wait c=%0d: got %b expected %b", c, b2.req_wait, e_wait);
      end
      n_tests++;
      if (b2.req_err !== e_err) begin
        n_fail++; $display("FAIL rand_err c=%0d: got %b expected %b", c, b2.req_err, e_err);
      end
      n_tests++;
      if (b2.req_load !== b2.ramload) begin
        n_fail++; $display("FAIL rand_load c=%0d: got %h expected %h", c, b2.req_load, b2.ramload);
      end
      owner = nxt_owner;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_read();
    test_round_robin();
    test_wrap();
    test_write();
    test_error();
    test_tbctrl();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
